// File: rtl/addr_manager_mq_if.sv
// addr_manager_mq_if: enqueue/dequeue handshake bundle for the multi-queue address manager
interface addr_manager_mq_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int QID_WIDTH  = 2
);
  logic                  enq_valid;
  logic [QID_WIDTH-1:0]  enq_qid;
  logic                  enq_ready;
  logic [ADDR_WIDTH-1:0] enq_addr;
  logic                  deq_valid;
  logic [QID_WIDTH-1:0]  deq_qid;
  logic                  deq_ready;
  logic [ADDR_WIDTH-1:0] deq_addr;
  modport master (
    output enq_valid, enq_qid, deq_valid, deq_qid,
    input  enq_ready, enq_addr, deq_ready, deq_addr
  );
  modport slave (
    input  enq_valid, enq_qid, deq_valid, deq_qid,
    output enq_ready, enq_addr, deq_ready, deq_addr
  );
endinterface

// File: rtl/addr_manager_mq.sv
// addr_manager_mq: free-list plus per-queue linked lists sharing one next-pointer table
module addr_manager_mq #(
  parameter int ADDR_WIDTH            = 6,
  parameter int ADDR_TABLE_DEPTH      = 64,
  parameter int NUM_QUEUES            = 4,
  parameter int QID_WIDTH             = 2,
  parameter int THRESHOLD_ALMOST_FULL = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  addr_manager_mq_if.slave      bus,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  almost_full,
  output logic [NUM_QUEUES-1:0] q_empty,
  output logic                  init_done
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE  = (ADDR_WIDTH+1)'(1);
  typedef enum logic {INIT, RUN} state_t;
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [ADDR_WIDTH-1:0]   free_head;
  logic [ADDR_WIDTH-1:0]   free_tail;
  logic [ADDR_WIDTH-1:0]   next_ptr [ADDR_TABLE_DEPTH];
  logic [ADDR_WIDTH-1:0]   head     [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0]   tail     [NUM_QUEUES];
  logic [ADDR_WIDTH:0]     cnt      [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]   enq_hit;
  logic [NUM_QUEUES-1:0]   deq_hit;
  logic                    run;
  logic                    do_enq;
  logic                    do_deq;
  assign run           = state == RUN;
  assign init_done     = run;
  assign bus.enq_ready = run && free_count != '0;
  assign bus.deq_ready = run && cnt[bus.deq_qid] != '0;
  assign bus.enq_addr  = free_head;
  assign bus.deq_addr  = head[bus.deq_qid];
  assign do_enq        = bus.enq_valid && bus.enq_ready;
  assign do_deq        = bus.deq_valid && bus.deq_ready;
  assign almost_full   = free_count < (ADDR_WIDTH+1)'(THRESHOLD_ALMOST_FULL);
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
    assign enq_hit[g] = do_enq && bus.enq_qid == QID_WIDTH'(g);
    assign deq_hit[g] = do_deq && bus.deq_qid == QID_WIDTH'(g);
    assign q_empty[g] = cnt[g] == '0;
  end
  // Link table: sequential fill during INIT, then queue-tail and free-tail links (never the same entry)
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      next_ptr[init_cnt] <= init_cnt + 1'b1;
    end else begin
      if (do_enq && cnt[bus.enq_qid] != '0) next_ptr[tail[bus.enq_qid]] <= bus.enq_addr;
      if (do_deq) next_ptr[free_tail] <= bus.deq_addr;
    end
  end
  // INIT/RUN control, free-list pointers and per-queue head/tail/count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= INIT;
      init_cnt   <= '0;
      free_head  <= '0;
      free_tail  <= '0;
      free_count <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        head[q] <= '0;
        tail[q] <= '0;
        cnt[q]  <= '0;
      end
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST) begin
        state      <= RUN;
        free_head  <= '0;
        free_tail  <= LAST;
        free_count <= (ADDR_WIDTH+1)'(ADDR_TABLE_DEPTH);
      end
    end else begin
      if (do_enq) free_head <= (do_deq && free_count == ONE) ? bus.deq_addr : next_ptr[free_head];
      else if (do_deq && free_count == '0) free_head <= bus.deq_addr;
      if (do_deq) free_tail <= bus.deq_addr;
      if (do_enq != do_deq) free_count <= do_enq ? free_count - ONE : free_count + ONE;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (enq_hit[q]) tail[q] <= bus.enq_addr;
        if (enq_hit[q] && (cnt[q] == '0 || (deq_hit[q] && cnt[q] == ONE))) head[q] <= bus.enq_addr;
        else if (deq_hit[q]) head[q] <= next_ptr[head[q]];
        cnt[q] <= cnt[q] + {{ADDR_WIDTH{1'b0}}, enq_hit[q]} - {{ADDR_WIDTH{1'b0}}, deq_hit[q]};
      end
    end
  end
endmodule

// File: tb/tb_addr_manager_mq.sv
// tb_addr_manager_mq: directed checks of init, allocation order, full/almost-full, coincident ops and reset
module tb_addr_manager_mq;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] free_count;
  logic       almost_full;
  logic [3:0] q_empty;
  logic       init_done;
  int         n_assert = 0;
  int         n_fail = 0;
  addr_manager_mq_if #(.ADDR_WIDTH(6), .QID_WIDTH(2)) bus ();
  addr_manager_mq dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .free_count(free_count), .almost_full(almost_full),
    .q_empty(q_empty), .init_done(init_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic e, input logic [1:0] eq, input logic d, input logic [1:0] dq);
    bus.enq_valid = e;
    bus.enq_qid   = eq;
    bus.deq_valid = d;
    bus.deq_qid   = dq;
    #1;
  endtask
  task automatic clk1;
    @(posedge clk);
    #1;
    bus.enq_valid = 1'b0;
    bus.deq_valid = 1'b0;
    #1;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_free_count"}, 32'(free_count), 0);
    check({tag, "_almost_full"}, 32'(almost_full), 1);
    check({tag, "_q_empty"}, 32'(q_empty), 4'hf);
    check({tag, "_enq_ready"}, 32'(bus.enq_ready), 0);
    check({tag, "_deq_ready"}, 32'(bus.deq_ready), 0);
  endtask
  task automatic release_and_init(input string tag);
    int cyc = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    while (!init_done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_init_cycles"}, 32'(cyc), 64);
    check({tag, "_free_count"}, 32'(free_count), 64);
    check({tag, "_almost_full"}, 32'(almost_full), 0);
    check({tag, "_q_empty"}, 32'(q_empty), 4'hf);
    check({tag, "_enq_ready"}, 32'(bus.enq_ready), 1);
  endtask
  initial begin
    drive(0, 0, 0, 0);
    #2;
    reset_checks("por");
    release_and_init("init1");
    // three enqueues then three dequeues on q1
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      check("q1_enq_addr", 32'(bus.enq_addr), i);
      clk1();
    end
    check("q1_full_free", 32'(free_count), 61);
    check("q1_nonempty", 32'(q_empty), 4'b1101);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1);
      check("q1_deq_ready", 32'(bus.deq_ready), 1);
      check("q1_deq_addr", 32'(bus.deq_addr), i);
      clk1();
    end
    check("q1_drained", 32'(q_empty), 4'hf);
    check("q1_free_back", 32'(free_count), 64);
    // reset and fill the whole table alternately into q0/q2
    rstn = 1'b0;
    #1;
    reset_checks("rst2");
    release_and_init("init2");
    for (int i = 0; i < 64; i++) begin
      drive(1, (i % 2 == 0) ? 2'd0 : 2'd2, 0, 0);
      check("fill_enq_addr", 32'(bus.enq_addr), i);
      clk1();
      check("fill_almost_full", 32'(almost_full), (63 - i < 8) ? 1 : 0);
    end
    check("full_enq_ready", 32'(bus.enq_ready), 0);
    check("full_free_count", 32'(free_count), 0);
    drive(1, 1, 0, 0);
    clk1();
    check("ignored_enq_free", 32'(free_count), 0);
    check("ignored_enq_empty", 32'(q_empty), 4'b1010);
    drive(0, 0, 1, 2);
    check("q2_deq_addr", 32'(bus.deq_addr), 1);
    clk1();
    check("refill_enq_ready", 32'(bus.enq_ready), 1);
    check("refill_enq_addr", 32'(bus.enq_addr), 1);
    check("refill_free", 32'(free_count), 1);
    // coincident enqueue/dequeue with a single free address
    drive(1, 1, 0, 0);
    check("q1_take_last", 32'(bus.enq_addr), 1);
    clk1();
    drive(0, 0, 1, 2);
    check("q2_deq_second", 32'(bus.deq_addr), 3);
    clk1();
    check("one_free", 32'(free_count), 1);
    drive(1, 0, 1, 1);
    check("both_enq_ready", 32'(bus.enq_ready), 1);
    check("both_deq_ready", 32'(bus.deq_ready), 1);
    check("both_enq_addr", 32'(bus.enq_addr), 3);
    check("both_deq_addr", 32'(bus.deq_addr), 1);
    clk1();
    check("both_free_count", 32'(free_count), 1);
    check("both_next_enq", 32'(bus.enq_addr), 1);
    check("both_q1_empty", 32'(q_empty[1]), 1);
    // asynchronous reset mid-cycle with queues populated
    drive(0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    reset_checks("midrst");
    release_and_init("init3");
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      check("restart_enq_addr", 32'(bus.enq_addr), i);
      clk1();
    end
    drive(1, 3, 0, 0);
    check("q3_enq_addr", 32'(bus.enq_addr), 5);
    clk1();
    // same-queue coincident ops on a single-entry queue
    drive(1, 3, 1, 3);
    check("q3_both_deq_addr", 32'(bus.deq_addr), 5);
    check("q3_both_enq_addr", 32'(bus.enq_addr), 6);
    clk1();
    check("q3_free_same", 32'(free_count), 58);
    drive(0, 0, 1, 3);
    check("q3_new_head", 32'(bus.deq_addr), 6);
    check("q3_still_one", 32'(q_empty), 4'b0110);
    clk1();
    check("q3_empty_after", 32'(q_empty), 4'b1110);
    check("q3_free_after", 32'(free_count), 59);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
